ap_chain_frame_sequencer: RTL
=============================

AP_CHAIN_FRAME_SEQUENCER -- requirements
Module: ap_chain_frame_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the frame count and counters.
REQ-002 SHALL have parameter TO_W, default 24, width of the timeout counter.
REQ-003 SHALL have port clock  in  1  single clock; all state on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port cfg_frames  in  CNT_W  frames per run; sampled on accepted cmd_go.
REQ-006 SHALL have port cfg_timeout  in  TO_W  no-progress cycle limit; 0 disables; sampled on accepted cmd_go.
REQ-007 SHALL have port cmd_go  in  1  run request pulse.
REQ-008 SHALL have port cmd_abort  in  1  abort request pulse.
REQ-009 SHALL have port sink_ready  in  1  downstream can accept a finished frame.
REQ-010 SHALL have port ap_start  out  1  kernel start, ap_ctrl_chain.
REQ-011 SHALL have port ap_ready  in  1  kernel accepted start.
REQ-012 SHALL have port ap_done  in  1  kernel frame complete.
REQ-013 SHALL have port ap_continue  out  1  kernel output consumed.
REQ-014 SHALL have ports busy, run_done, timeout_err  out  1 each  state not IDLE / one-cycle run-complete pulse / sticky timeout flag.
REQ-015 SHALL have ports frames_started, frames_done  out  CNT_W each  start and done handshakes accepted in the current run.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, ERR.
REQ-017 IDLE: cmd_go with cfg_frames!=0 SHALL latch cfg_frames as target and cfg_timeout, clear both counters, clear timeout_err, and enter RUN next cycle.
REQ-018 IDLE: cmd_go with cfg_frames==0 SHALL pulse run_done in the next cycle and remain in IDLE.
REQ-019 IDLE: cmd_go and cmd_abort in the same cycle SHALL ignore cmd_go.
REQ-020 RUN: ap_start SHALL be registered high while frames_started<target.
REQ-021 A start handshake is ap_start&&ap_ready; each handshake SHALL increment frames_started by 1.
REQ-022 When the final start handshake occurs, ap_start SHALL be low from the next cycle and the FSM SHALL enter DRAIN.
REQ-023 Once raised, ap_start SHALL NOT drop before ap_ready, including on abort.
REQ-024 ap_continue SHALL equal sink_ready in RUN and DRAIN, SHALL be 1 in ERR, and SHALL be 0 in IDLE.
REQ-025 A done handshake is ap_done&&ap_continue; each SHALL increment frames_done in RUN and DRAIN; frames_done SHALL never exceed frames_started.
REQ-026 Start and done handshakes in the same cycle SHALL both be counted.
REQ-027 DRAIN: when frames_done reaches frames_started, the FSM SHALL go to IDLE and pulse run_done for exactly one cycle.
REQ-028 RUN: cmd_abort SHALL set target=frames_started, or frames_started+1 if ap_start is high without ap_ready that cycle; the normal DRAIN path then applies.
REQ-029 Timeout counter SHALL count cycles in RUN/DRAIN with frames outstanding or ap_start high, clear on any handshake, and do nothing when the latched timeout is 0.
REQ-030 When the timeout counter equals the latched timeout, the FSM SHALL enter ERR with ap_start=0 and timeout_err=1.
REQ-031 ERR SHALL leave only on cmd_abort, to IDLE, with no run_done pulse; timeout_err SHALL stay high until the next accepted cmd_go.
REQ-032 cmd_go outside IDLE SHALL be ignored.
REQ-033 Counters SHALL NOT wrap; target<=2^CNT_W-1 bounds them.

Reset
REQ-034 reset SHALL asynchronously force IDLE, with ap_start=0, ap_continue=0, busy=0, run_done=0, timeout_err=0, counters=0, latched target/timeout=0.
REQ-035 reset mid-run SHALL drop ap_start immediately; no handshake SHALL be counted while reset is high.

Verification
REQ-036 cfg_frames=3, ap_ready one cycle after each start, ap_done two cycles later, sink_ready=1 -> 3 start and 3 done handshakes; run_done one cycle after 3rd done; counters 3/3.
REQ-037 cfg_frames=2, sink_ready=0 for 10 cycles after first ap_done -> ap_continue=0, frames_done stays 0 until sink_ready rises; run_done after both dones.
REQ-038 cfg_frames=5, cmd_abort while ap_start high and ap_ready low (frames_started=1) -> ap_start held until ap_ready; target=2; run_done after 2 dones.
REQ-039 cfg_timeout=8, kernel never asserts ap_ready -> ERR at 8th stalled cycle; ap_start=0; timeout_err=1; cmd_abort -> IDLE; next cmd_go clears timeout_err.
REQ-040 cfg_frames=0 with cmd_go -> run_done pulse, busy stays 0; cmd_go+cmd_abort same cycle -> no action.
REQ-041 reset asserted mid-RUN between clock edges -> all outputs 0 immediately; after release, a fresh cmd_go runs normally.

Source files
------------

// File: rtl/ap_chain_frame_sequencer.sv
// Frame sequencer for an ap_ctrl_chain kernel: issues cfg_frames start handshakes,
// drains the matching done handshakes, and supports abort and a no-progress timeout.
module ap_chain_frame_sequencer #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TO_W  = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] cfg_frames,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             cmd_go,
  input  logic             cmd_abort,
  input  logic             sink_ready,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic             run_done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] frames_started,
  output logic [CNT_W-1:0] frames_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   started_q, started_d;
  logic [CNT_W-1:0]   done_q, done_d;
  logic [TO_W-1:0]    tmo_lim_q, tmo_lim_d;
  logic [TO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic               ap_start_q, ap_start_d;
  logic               run_done_q, run_done_d;
  logic               tmo_err_q, tmo_err_d;

  logic               go_ok;
  logic               active;
  logic               start_hs;
  logic               done_hs;
  logic               tmo_pending;

  assign go_ok    = cmd_go && !cmd_abort;
  assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign start_hs = ap_start_q && ap_ready;
  // A done is only accepted for a frame that was actually started.
  assign done_hs  = active && ap_done && ap_continue && (done_q != started_q);
  assign tmo_pending = ap_start_q || (started_q != done_q);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational processes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      target_q   <= '0;
      started_q  <= '0;
      done_q     <= '0;
      tmo_lim_q  <= '0;
      tmo_cnt_q  <= '0;
      ap_start_q <= 1'b0;
      run_done_q <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      started_q  <= started_d;
      done_q     <= done_d;
      tmo_lim_q  <= tmo_lim_d;
      tmo_cnt_q  <= tmo_cnt_d;
      ap_start_q <= ap_start_d;
      run_done_q <= run_done_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    target_d   = target_q;
    started_d  = started_q;
    done_d     = done_q;
    tmo_lim_d  = tmo_lim_q;
    tmo_cnt_d  = tmo_cnt_q;
    ap_start_d = ap_start_q;
    run_done_d = 1'b0;
    tmo_err_d  = tmo_err_q;

    unique case (state_q)
      ST_IDLE: begin
        ap_start_d = 1'b0;
        if (go_ok) begin
          if (cfg_frames != '0) begin
            state_d    = ST_RUN;
            target_d   = cfg_frames;
            tmo_lim_d  = cfg_timeout;
            started_d  = '0;
            done_d     = '0;
            tmo_cnt_d  = '0;
            tmo_err_d  = 1'b0;
            ap_start_d = 1'b1;
          end else begin
            run_done_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (start_hs) started_d = started_q + 1'b1;
        if (done_hs)  done_d    = done_q + 1'b1;
        // An outstanding start request still has to complete, so it stays in the target.
        if (cmd_abort) target_d = started_q + {{(CNT_W-1){1'b0}}, ap_start_q};
        if (started_d == target_d) begin
          state_d    = ST_DRAIN;
          ap_start_d = 1'b0;
        end else begin
          ap_start_d = 1'b1;
        end
      end

      ST_DRAIN: begin
        ap_start_d = 1'b0;
        if (done_hs) done_d = done_q + 1'b1;
        if (done_d == started_q) begin
          state_d    = ST_IDLE;
          run_done_d = 1'b1;
        end
      end

      ST_ERR: begin
        ap_start_d = 1'b0;
        if (cmd_abort) state_d = ST_IDLE;
      end

      default: begin
        state_d    = ST_IDLE;
        ap_start_d = 1'b0;
      end
    endcase

    // No-progress watchdog; a timeout overrides the start-hold rule and forces ERR.
    if (active && (tmo_lim_q != '0)) begin
      if (start_hs || done_hs) begin
        tmo_cnt_d = '0;
      end else if (tmo_pending) begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (tmo_cnt_d == tmo_lim_q) begin
          state_d    = ST_ERR;
          ap_start_d = 1'b0;
          run_done_d = 1'b0;
          tmo_err_d  = 1'b1;
        end
      end else begin
        tmo_cnt_d = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin : outputs
    ap_continue = 1'b0;
    unique case (state_q)
      ST_RUN, ST_DRAIN: ap_continue = sink_ready;
      ST_ERR:           ap_continue = 1'b1;
      default:          ap_continue = 1'b0;
    endcase
  end

  assign busy           = (state_q != ST_IDLE);
  assign ap_start       = ap_start_q;
  assign run_done       = run_done_q;
  assign timeout_err    = tmo_err_q;
  assign frames_started = started_q;
  assign frames_done    = done_q;

  // ---------------------------------------------------------------------------
  // Protocol invariants
  // ---------------------------------------------------------------------------
  a_start_held : assert property (@(posedge clock) disable iff (reset)
    (ap_start_q && !ap_ready) |=> (ap_start_q || (state_q == ST_ERR)));

  a_done_bound : assert property (@(posedge clock) disable iff (reset)
    (done_q <= started_q));

  a_start_bound : assert property (@(posedge clock) disable iff (reset)
    (started_q <= target_q));

endmodule
